// File: rtl/conv_sched.sv
// conv_sched: turns a configured layer geometry into image/kernel buffer read beats,
// groups windows into pooled outputs and waits for each result. Optional SCHED_STALL_CNT_EN.
module conv_sched #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int ADDR_WIDTH = 16,
    parameter logic [CFG_AWIDTH-1:0] CFG_SCHED_WIN = 'h10,
    parameter logic [CFG_AWIDTH-1:0] CFG_SCHED_OUT = 'h11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_DWIDTH-1:0] cfg_data,
    input  logic [CFG_AWIDTH-1:0] cfg_addr,
    input  logic                  cfg_valid,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] img_addr,
    output logic [ADDR_WIDTH-1:0] ker_addr,
    output logic                  image_val,
    output logic                  image_last,
    input  logic                  image_rdy,
    input  logic                  result_val,
    input  logic                  result_rdy,
    output logic [31:0]           stall_cnt
);

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_ISSUE = 4'b0010;
    localparam logic [3:0] ST_WAIT  = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

    logic [15:0] cfg_win_nb_q;
    logic [15:0] cfg_img_base_q;
    logic [15:0] cfg_out_nb_q;
    logic [7:0]  cfg_pool_nb_q;

    logic [15:0] win_w_q;
    logic [15:0] out_w_q;
    logic [7:0]  pool_w_q;

    logic [3:0]            state_q, state_d;
    logic [15:0]           beat_q, beat_d;
    logic [7:0]            win_cnt_q, win_cnt_d;
    logic [15:0]           out_cnt_q, out_cnt_d;
    logic [ADDR_WIDTH-1:0] img_q, img_d;
    logic [ADDR_WIDTH-1:0] ker_q, ker_d;
    logic                  val_q, val_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;

    logic        ld_work;
    logic        accept;
    logic        res_hs;
    logic [15:0] cfg_win_eff;

    logic unused_cfg;
    assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:24];

    assign cfg_win_eff = (cfg_win_nb_q == 16'd0) ? 16'd1 : cfg_win_nb_q;
    assign accept      = val_q & image_rdy;
    assign res_hs      = result_val & result_rdy;
    assign ld_work     = state_q[0] & start;

    // Cfg registers survive reset; they are only ever changed by bus writes.
    always_ff @(posedge clk) begin
        if (cfg_valid && cfg_addr == CFG_SCHED_WIN) begin
            cfg_win_nb_q   <= cfg_data[15:0];
            cfg_img_base_q <= cfg_data[31:16];
        end
        if (cfg_valid && cfg_addr == CFG_SCHED_OUT) begin
            cfg_out_nb_q  <= cfg_data[15:0];
            cfg_pool_nb_q <= cfg_data[23:16];
        end
        if (ld_work) begin
            win_w_q  <= cfg_win_eff;
            out_w_q  <= cfg_out_nb_q;
            pool_w_q <= cfg_pool_nb_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        win_cnt_d = win_cnt_q;
        out_cnt_d = out_cnt_q;
        img_d     = img_q;
        ker_d     = ker_q;
        val_d     = val_q;
        last_d    = last_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_out_nb_q == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        val_d   = 1'b1;
                        img_d   = ADDR_WIDTH'(cfg_img_base_q);
                        beat_d  = 16'd0;
                        last_d  = (cfg_win_eff == 16'd1);
                    end
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    img_d = img_q + 1'b1;
                    if (last_q) begin
                        beat_d = 16'd0;
                        if (win_cnt_q < pool_w_q) begin
                            win_cnt_d = win_cnt_q + 8'd1;
                            last_d    = (win_w_q == 16'd1);
                        end else begin
                            win_cnt_d = 8'd0;
                            state_d   = ST_WAIT;
                            val_d     = 1'b0;
                            last_d    = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                        last_d = (beat_q + 16'd1 == win_w_q - 16'd1);
                    end
                end
            end
            ST_WAIT: begin
                if (res_hs) begin
                    if (out_cnt_q == out_w_q - 16'd1) begin
                        out_cnt_d = 16'd0;
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                    end else begin
                        out_cnt_d = out_cnt_q + 16'd1;
                        state_d   = ST_ISSUE;
                        val_d     = 1'b1;
                        beat_d    = 16'd0;
                        last_d    = (win_w_q == 16'd1);
                    end
                end
            end
            ST_DONE: begin
                // The zero-output path arrives here with done low and pulses it one cycle later.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ker_d = ADDR_WIDTH'(beat_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= 16'd0;
            win_cnt_q <= 8'd0;
            out_cnt_q <= 16'd0;
            img_q     <= '0;
            ker_q     <= '0;
            val_q     <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            win_cnt_q <= win_cnt_d;
            out_cnt_q <= out_cnt_d;
            img_q     <= img_d;
            ker_q     <= ker_d;
            val_q     <= val_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (ld_work) begin
            stall_d = 32'd0;
        end else if (val_q && !image_rdy && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

    assign busy       = ~state_q[0];
    assign done       = done_q;
    assign img_addr   = img_q;
    assign ker_addr   = ker_q;
    assign image_val  = val_q;
    assign image_last = last_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed self-checking bench for conv_sched; stall expectations follow SCHED_STALL_CNT_EN.
module tb_conv_sched;

    localparam logic [4:0] A_WIN = 5'h10;
    localparam logic [4:0] A_OUT = 5'h11;
`ifdef SCHED_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd8;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_data = '0;
    logic [4:0]  cfg_addr = '0;
    logic        cfg_valid = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, image_val, image_last;
    logic [15:0] img_addr, ker_addr;
    logic        image_rdy = 1'b1;
    logic        result_val = 1'b0;
    logic        result_rdy = 1'b0;
    logic [31:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    conv_sched #(
        .CFG_DWIDTH(32), .CFG_AWIDTH(5), .ADDR_WIDTH(16),
        .CFG_SCHED_WIN(A_WIN), .CFG_SCHED_OUT(A_OUT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
        .cfg_valid(cfg_valid), .start(start), .busy(busy), .done(done),
        .img_addr(img_addr), .ker_addr(ker_addr), .image_val(image_val),
        .image_last(image_last), .image_rdy(image_rdy), .result_val(result_val),
        .result_rdy(result_rdy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat_chk(input int b, input logic [15:0] ea, input int k, input int win);
        check($sformatf("val b%0d", b), {31'd0, image_val}, 32'd1);
        check($sformatf("img b%0d", b), {16'd0, img_addr}, {16'd0, ea});
        check($sformatf("ker b%0d", b), {16'd0, ker_addr}, k);
        check($sformatf("last b%0d", b), {31'd0, image_last}, {31'd0, (k == win - 1)});
    endtask

    task automatic issue_beats(input int nb, input logic [15:0] img0, input int win, input bit stall);
        logic [15:0] ea;
        int k;
        for (int b = 0; b < nb; b++) begin
            ea = img0 + 16'(b);
            k  = b % win;
            if (stall) begin
                image_rdy = 1'b0;
                repeat (2) begin
                    beat_chk(b, ea, k, win);
                    tick();
                end
                image_rdy = 1'b1;
            end
            beat_chk(b, ea, k, win);
            tick();
        end
    endtask

    task automatic handshake();
        result_val = 1'b1;
        result_rdy = 1'b1;
        tick();
        result_val = 1'b0;
        result_rdy = 1'b0;
    endtask

    task automatic finish_layer(input string tag);
        handshake();
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy@done"}, {31'd0, busy}, 32'd1);
        tick();
        check({tag, " done fall"}, {31'd0, done}, 32'd0);
        check({tag, " busy fall"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst val", {31'd0, image_val}, 32'd0);
        check("rst last", {31'd0, image_last}, 32'd0);
        check("rst img", {16'd0, img_addr}, 32'd0);
        check("rst ker", {16'd0, ker_addr}, 32'd0);
        check("rst stall", stall_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // basic: two single-window groups
        cfg_wr(A_WIN, {16'h0100, 16'd4});
        cfg_wr(A_OUT, {8'd0, 8'd0, 16'd2});
        do_start();
        check("t1 busy", {31'd0, busy}, 32'd1);
        issue_beats(4, 16'h0100, 4, 1'b0);
        check("t1 val fall g0", {31'd0, image_val}, 32'd0);
        tick();
        tick();
        check("t1 hs ignored wait", {31'd0, image_val}, 32'd0);
        handshake();
        issue_beats(4, 16'h0104, 4, 1'b0);
        check("t1 val fall g1", {31'd0, image_val}, 32'd0);
        check("t1 img held", {16'd0, img_addr}, 32'h0108);
        finish_layer("t1");

        // pooled group of three windows
        cfg_wr(A_WIN, {16'h0200, 16'd3});
        cfg_wr(A_OUT, {8'd0, 8'd2, 16'd1});
        do_start();
        issue_beats(9, 16'h0200, 3, 1'b0);
        check("t2 wait val", {31'd0, image_val}, 32'd0);
        check("t2 wait busy", {31'd0, busy}, 32'd1);
        finish_layer("t2");

        // backpressure
        cfg_wr(A_WIN, {16'h0300, 16'd4});
        cfg_wr(A_OUT, {8'd0, 8'd0, 16'd1});
        do_start();
        issue_beats(4, 16'h0300, 4, 1'b1);
        check("t3 val fall", {31'd0, image_val}, 32'd0);
        check("t3 stall", stall_cnt, STALL_EXP);
        finish_layer("t3");

        // zero outputs: done two cycles after start, no beats
        cfg_wr(A_OUT, {8'd0, 8'd0, 16'd0});
        do_start();
        check("t4 c1 done", {31'd0, done}, 32'd0);
        check("t4 c1 val", {31'd0, image_val}, 32'd0);
        check("t4 c1 busy", {31'd0, busy}, 32'd1);
        check("t4 stall clr", stall_cnt, 32'd0);
        tick();
        check("t4 c2 done", {31'd0, done}, 32'd1);
        check("t4 c2 val", {31'd0, image_val}, 32'd0);
        tick();
        check("t4 c3 done", {31'd0, done}, 32'd0);
        check("t4 c3 busy", {31'd0, busy}, 32'd0);

        // win_nb==0 behaves as 1
        cfg_wr(A_WIN, {16'h0400, 16'd0});
        cfg_wr(A_OUT, {8'd0, 8'd1, 16'd1});
        do_start();
        issue_beats(2, 16'h0400, 1, 1'b0);
        check("t5 val fall", {31'd0, image_val}, 32'd0);
        finish_layer("t5");

        // reset mid-window then restart
        cfg_wr(A_WIN, {16'h0500, 16'd4});
        cfg_wr(A_OUT, {8'd0, 8'd0, 16'd1});
        do_start();
        tick();
        tick();
        check("t6 pre-rst img", {16'd0, img_addr}, 32'h0502);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 rst busy", {31'd0, busy}, 32'd0);
        check("t6 rst val", {31'd0, image_val}, 32'd0);
        check("t6 rst img", {16'd0, img_addr}, 32'd0);
        check("t6 rst ker", {16'd0, ker_addr}, 32'd0);
        do_start();
        issue_beats(4, 16'h0500, 4, 1'b0);
        finish_layer("t6");

        // start and cfg write while busy leave the running layer alone
        do_start();
        start     = 1'b1;
        cfg_addr  = A_WIN;
        cfg_data  = {16'h0700, 16'd2};
        cfg_valid = 1'b1;
        issue_beats(4, 16'h0500, 4, 1'b0);
        cfg_valid = 1'b0;
        check("t7 wait val", {31'd0, image_val}, 32'd0);
        start = 1'b0;
        handshake();
        check("t7 done", {31'd0, done}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t7 start@done busy", {31'd0, busy}, 32'd0);
        check("t7 start@done val", {31'd0, image_val}, 32'd0);
        tick();
        check("t7 still idle", {31'd0, busy}, 32'd0);
        do_start();
        issue_beats(2, 16'h0700, 2, 1'b0);
        finish_layer("t7b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
